// File: rtl/mem_port.sv
// Request/ack scratch memory port: byte/half/word, little-endian, wait states.
// Define MEM_PORT_FAULT_EN to fault misaligned and out-of-range accesses.
module mem_port #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              fault
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic           phase;
    logic [AW-1:0]  idx_q;
    logic           we_q;
    logic [1:0]     size_q;
    logic           uns_q;
    logic [31:0]    wdata_q;
    logic           bad;
    logic           wr_en;
    logic [31:0]    ld_val;
    logic [AW-1:0]  i1, i2, i3;
    logic [7:0]     mem [DEPTH];

`ifdef MEM_PORT_FAULT_EN
    logic           oor_q;
    logic           mis_q;
`else
    logic           unused_hi;
    assign unused_hi = |(addr >> AW);
`endif

    // Index arithmetic is AW bits wide, so wrap modulo DEPTH is free.
    assign i1 = idx_q + AW'(1);
    assign i2 = idx_q + AW'(2);
    assign i3 = idx_q + AW'(3);

    always_comb begin
        bad = (size_q == 2'd3);
`ifdef MEM_PORT_FAULT_EN
        if (oor_q || mis_q) bad = 1'b1;
`endif
    end

    always_comb begin
        ld_val = '0;
        case (size_q)
            2'd0: ld_val = {{24{~uns_q & mem[idx_q][7]}}, mem[idx_q]};
            2'd1: ld_val = {{16{~uns_q & mem[i1][7]}}, mem[i1], mem[idx_q]};
            2'd2: ld_val = {mem[i3], mem[i2], mem[i1], mem[idx_q]};
            default: ld_val = '0;
        endcase
        if (we_q || bad) ld_val = '0;
    end

    assign wr_en = rst && (state == S_ACCESS) && !phase && we_q && !bad;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx_q] <= wdata_q[7:0];
            if (size_q != 2'd0) mem[i1] <= wdata_q[15:8];
            if (size_q == 2'd2) begin
                mem[i2] <= wdata_q[23:16];
                mem[i3] <= wdata_q[31:24];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            ack   <= 1'b0;
            fault <= 1'b0;
            rdata <= '0;
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack <= 1'b0;
                    if (req) begin
                        idx_q   <= addr[AW-1:0];
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= uns;
                        wdata_q <= wdata;
`ifdef MEM_PORT_FAULT_EN
                        oor_q   <= |(addr >> AW);
                        mis_q   <= (size == 2'd1 && addr[0]) ||
                                   (size == 2'd2 && addr[1:0] != 2'b00);
`endif
                        busy    <= 1'b1;
                        phase   <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state <= S_ACCESS;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_ACCESS;
                    else cnt <= cnt - 4'd1;
                end
                // First edge commits the store, second registers the response.
                S_ACCESS: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        state <= S_RESP;
                        ack   <= 1'b1;
                        rdata <= ld_val;
                        fault <= bad;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    rdata <= '0;
                    fault <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port.sv
// Testbench for mem_port: directed table, reset abort, back-to-back timing,
// and randomized accesses against a byte-array reference model.
module tb_mem_port;
    localparam int W     = 1;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req0;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        busy, ack, fault;
    logic [31:0] rdata;
    logic        busy0, ack0, fault0;
    logic [31:0] rdata0;

    int total  = 0;
    int passed = 0;

    logic [7:0] mem_m [DEPTH];

    always #5 clk = ~clk;

    mem_port #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(W)) u_dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .we(we),
        .size(size), .uns(uns), .wdata(wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .fault(fault)
    );

    mem_port #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .addr(addr), .we(we),
        .size(size), .uns(uns), .wdata(wdata),
        .busy(busy0), .ack(ack0), .rdata(rdata0), .fault(fault0)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic void model(input logic w, input logic [1:0] s,
                                  input logic u, input logic [31:0] a,
                                  input logic [31:0] d,
                                  output logic [31:0] r, output logic f);
        int n    = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        int base = int'(a % DEPTH);
        r = '0;
        f = (s == 2'd3);
`ifdef MEM_PORT_FAULT_EN
        if ((s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00) ||
            a >= DEPTH) f = 1'b1;
`endif
        if (f) return;
        if (w) begin
            for (int k = 0; k < n; k++)
                mem_m[(base + k) % DEPTH] = 8'((d >> (8 * k)) & 32'hFF);
        end else begin
            for (int k = 0; k < n; k++)
                r = r | (32'(mem_m[(base + k) % DEPTH]) << (8 * k));
            if (!u && n == 1 && r[7]) r = r | 32'hFFFF_FF00;
            if (!u && n == 2 && r[15]) r = r | 32'hFFFF_0000;
        end
    endfunction

    task automatic do_req(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] r, output logic f);
        int   lat = 0;
        logic got = 1'b0;
        @(negedge clk);
        req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
        @(posedge clk);
        #1;
        check("accept busy", 32'(busy), 32'd1);
        req   = 1'b0;
        addr  = $urandom;
        wdata = $urandom;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (ack) got = 1'b1;
        end
        check("ack seen", 32'(got), 32'd1);
        check("ack latency", 32'(lat), 32'(W + 2));
        r = rdata;
        f = fault;
        @(posedge clk);
        #1;
        check("ack one cycle", 32'(ack), 32'd0);
        check("busy clear", 32'(busy), 32'd0);
    endtask

    function automatic void add(input string n, input logic w,
                                input logic [1:0] s, input logic u,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] r, input logic f);
        vec_t v;
        v.name = n; v.we = w; v.size = s; v.uns = u;
        v.addr = a; v.wdata = d; v.rdata = r; v.fault = f;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [31:0] r, er;
        logic        f, ef;
        int          acks, rises, last, cyc;
        logic        pb;

        rst = 1'b0; req = 1'b0; req0 = 1'b0; addr = '0; we = 1'b0;
        size = '0; uns = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst ack", 32'(ack), 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        add("st w 10", 1, 2, 0, 32'h10, 32'hDEAD_BEEF, 0, 0);
        add("ld w 10", 0, 2, 0, 32'h10, 0, 32'hDEAD_BEEF, 0);
        add("st w 20", 1, 2, 0, 32'h20, 0, 0, 0);
        add("st b 21", 1, 0, 0, 32'h21, 32'h0000_0080, 0, 0);
        add("ld b 21 s", 0, 0, 0, 32'h21, 0, 32'hFFFF_FF80, 0);
        add("ld b 21 u", 0, 0, 1, 32'h21, 0, 32'h0000_0080, 0);
        add("ld w 20", 0, 2, 0, 32'h20, 0, 32'h0000_8000, 0);
        add("ld h 12 s", 0, 1, 0, 32'h12, 0, 32'hFFFF_DEAD, 0);
        add("ld h 12 u", 0, 1, 1, 32'h12, 0, 32'h0000_DEAD, 0);
        add("st w 14", 1, 2, 0, 32'h14, 32'h1122_3344, 0, 0);
        add("st w ffc", 1, 2, 0, 32'hFFC, 32'h4433_2211, 0, 0);
        add("st w 000", 1, 2, 0, 32'h0, 32'h5566_7711, 0, 0);
`ifdef MEM_PORT_FAULT_EN
        add("ld h 13", 0, 1, 1, 32'h13, 0, 0, 1);
        add("ld h fff", 0, 1, 1, 32'hFFF, 0, 0, 1);
        add("ld w ffe", 0, 2, 0, 32'hFFE, 0, 0, 1);
        add("ld w 1010", 0, 2, 0, 32'h1010, 0, 0, 1);
        add("ld b 1013", 0, 0, 0, 32'h1013, 0, 0, 1);
`else
        add("ld h 13", 0, 1, 1, 32'h13, 0, 32'h0000_44DE, 0);
        add("ld h fff", 0, 1, 1, 32'hFFF, 0, 32'h0000_1144, 0);
        add("ld w ffe", 0, 2, 0, 32'hFFE, 0, 32'h7711_4433, 0);
        add("ld w 1010", 0, 2, 0, 32'h1010, 0, 32'hDEAD_BEEF, 0);
        add("ld b 1013", 0, 0, 0, 32'h1013, 0, 32'hFFFF_FFDE, 0);
`endif
        add("ld sz3", 0, 3, 0, 32'h10, 0, 0, 1);
        add("st sz3", 1, 3, 0, 32'h10, 32'h1234_5678, 0, 1);
        add("ld w 10 kept", 0, 2, 0, 32'h10, 0, 32'hDEAD_BEEF, 0);

        foreach (tbl[i]) begin
            do_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
                   tbl[i].wdata, r, f);
            check({tbl[i].name, " rdata"}, r, tbl[i].rdata);
            check({tbl[i].name, " fault"}, 32'(f), 32'(tbl[i].fault));
            model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
                  tbl[i].wdata, er, ef);
        end

        // Reset during WAIT must drop the pending store.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h10;
        wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        check("abort accept", 32'(busy), 32'd1);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        acks = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack || busy) acks++;
        end
        check("abort no ack", 32'(acks), 32'd0);
        do_req(0, 2, 0, 32'h10, 0, r, f);
        check("abort old data", r, 32'hDEAD_BEEF);

        // Zero wait states with req held high: acks every 4 cycles.
        @(negedge clk);
        req0 = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0;
        addr = 32'h40; wdata = 32'h0BAD_F00D;
        acks = 0; rises = 0; last = -1; pb = 1'b0;
        for (cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk);
            #1;
            if (busy0 && !pb) rises++;
            pb = busy0;
            if (ack0) begin
                if (last >= 0) check("b2b spacing", 32'(cyc - last), 32'd4);
                check("b2b rdata", rdata0, 32'd0);
                last = cyc;
                acks++;
            end
        end
        req0 = 1'b0;
        check("b2b ack count", 32'(acks >= 6), 32'd1);
        check("b2b accepts", 32'(rises - acks >= 0 && rises - acks <= 1),
              32'd1);
        repeat (6) @(posedge clk);

        for (int a = 0; a < 72; a += 4) begin
            do_req(1, 2, 0, 32'(a), $urandom, r, f);
            model(1, 2, 0, 32'(a), 32'h0, er, ef);
        end
        for (int a = 0; a < 72; a += 4) begin
            logic [31:0] d = $urandom;
            do_req(1, 2, 0, 32'(a), d, r, f);
            model(1, 2, 0, 32'(a), d, er, ef);
        end

        for (int i = 0; i < 150; i++) begin
            logic        rw = 1'($urandom_range(0, 1));
            logic [1:0]  rs = 2'($urandom_range(0, 3));
            logic        ru = 1'($urandom_range(0, 1));
            logic [31:0] ra = 32'($urandom_range(0, 63));
            logic [31:0] rd = $urandom;
            if ($urandom_range(0, 7) == 0) ra = ra | 32'h1000;
            model(rw, rs, ru, ra, rd, er, ef);
            do_req(rw, rs, ru, ra, rd, r, f);
            check("rand rdata", r, er);
            check("rand fault", 32'(f), 32'(ef));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
